spi_reg_responder: RTL and testbench
====================================

Name: spi_reg_responder

Overview:
- SPI mode-0 responder on the CPLD. It is the target end of the CPU's 1V8 SPI0 bus, the opposite role to the CPLD's own PLL-configuration SPI initiator.
- Exposes a small register file to the host: an ID byte, the c66x sequencer state, power-good flags, a control byte, a scratch byte and a camera-trigger pulse generator.
- Oversampled entirely in the sysclk domain, which is the 3.3-5.5 MHz internal oscillator.

Parameters:
- DEVICE_ID, 8'hA5, value returned at address 0x00.
- PULSE_CYCLES, 16, width of the camera_trigger pulse in sysclk cycles; legal range 1..65535.
- CTRL_RESET, 8'h00, reset value of the control register.

Ports:
- sysclk  in  1  system clock (internal oscillator).
- reset_INV  in  1  asynchronous, active-low reset.
- spi_clk  in  1  host SCLK, asynchronous to sysclk.
- spi_mosi  in  1  host MOSI, asynchronous.
- spi_cs_INV  in  1  host chip select, active low, asynchronous.
- spi_miso  out  1  responder MISO; registered output.
- seq_state  in  4  c66x sequencer state.
- pg_flags  in  8  power-good vector, captured at read time.
- ctrl  out  8  control register (ioboard reset requests, gps enable, etc.).
- camera_trigger  out  1  pulse, PULSE_CYCLES wide.
- frame_err  out  1  sticky flag: a frame was aborted by CS deasserting early; cleared by reading address 0x06.

Behaviour:
- Reset values:
  - spi_miso=0, ctrl=CTRL_RESET, camera_trigger=0, frame_err=0, scratch=0.
  - State machine in IDLE, bit counter 0.
- Synchronisers and edge detection:
  - spi_clk, spi_mosi and spi_cs_INV each pass through a 2-FF synchroniser.
  - A third FF on clk and cs provides edge detection.
  - Input-to-action latency is 3 sysclk.
- SCLK limits: high and low phases must each be at least 4 sysclk; setup/hold beyond that is not guaranteed.
- Frame format, MSB first, 16 bits:
  - Byte 0 = {rw, addr[6:0]}, with rw=1 for read.
  - Byte 1 = data.
- MOSI is sampled on the synchronised SCLK rising edge.
- MISO updates on the synchronised SCLK falling edge; the first bit of a frame is driven on the CS falling edge.
- State machine:
  - IDLE: wait for CS fall. On CS fall → CMD, with bitcnt=0, and MISO driven with bit7 of the status byte {seq_state, 4'b0}.
  - CMD: shift 8 bits of MOSI.
    - On the 8th rising edge: latch rw and addr, and snapshot the read data into the tx shift register (the snapshot is stable for the rest of the frame).
    - Then → DATA.
    - MISO bit7 of the read data is presented on the falling edge after the 8th rising edge.
  - DATA: shift 8 bits. On the 16th rising edge:
    - If write, commit the data byte.
    - If read of 0x06, clear frame_err.
    - Then → DONE.
  - DONE: ignore further SCLK edges; MISO=0; on CS rise → IDLE.
- CS rise in CMD or DATA (fewer than 16 bits): no commit, frame_err=1, → IDLE. A CS rise always forces IDLE from any state.
- CS fall while already in CMD/DATA is not possible without a rise; rise handling covers resynchronisation.
- While CS is high, spi_miso=0. MISO is always driven (not tri-state), matching the bank's push-pull convention.
- Register map:
  - 0x00: R, DEVICE_ID.
  - 0x01: R, {4'b0, seq_state}.
  - 0x02: R, pg_flags.
  - 0x03: R/W, ctrl.
  - 0x04: R/W, scratch.
  - 0x05: W, data bit0=1 fires camera_trigger.
  - 0x06: R, {7'b0, frame_err}, clear-on-read.
  - Other addresses: read 8'h00, writes ignored.
- Camera trigger:
  - Writing 0x05 with bit0=1 loads a 16-bit down-counter with PULSE_CYCLES.
  - camera_trigger=1 while the counter is non-zero.
  - A retrigger while active reloads the counter, extending the pulse; there is no glitch low.
- Simultaneous events:
  - A frame commit in the same cycle as a CS rise: the 16th rising edge is processed first, so the commit occurs.
  - A 0x06 read clear and a new abort cannot coincide, because they occur in different frames.
- Asynchronous reset mid-frame: immediate return to reset values; the in-flight frame is lost and no commit occurs.

Decomposition:
- Shared package spi_reg_pkg holds:
  - address constants (ADDR_ID..ADDR_ERR);
  - the state enum (IDLE/CMD/DATA/DONE);
  - FRAME_BITS=16.
- One sub-module, spi_pin_sync: 3-stage synchroniser plus rise/fall detect. It is instantiated for clk and cs; mosi uses only 2 stages.

Test Plan:
- Read ID: CS low, shift 0x80, 0x00 at SCLK = sysclk/10 → MISO byte1 = 0xA5; byte0 MISO = {seq_state, 0000}; frame_err stays 0.
- Write/readback: write 0x03←0x5A → ctrl=0x5A within 3 sysclk of the 16th edge; then read 0x83 → 0x5A. Write 0x7F←0xFF (unmapped) → no register changes.
- Snapshot: read 0x82 with pg_flags=0x3C, change pg_flags to 0xFF mid-byte-1 → MISO returns 0x3C.
- Abort: write 0x04←0x11 with CS rising after 12 bits → scratch unchanged (0), frame_err=1; read 0x86 → 0x01; a second read 0x86 → 0x00.
- Trigger: PULSE_CYCLES=16, write 0x05←0x01 → camera_trigger high for exactly 16 sysclk; re-write at cycle 10 → total high time 26 cycles, with no low gap.
- Reset: assert reset_INV low mid-DATA of a write 0x03←0xFF → ctrl=CTRL_RESET and spi_miso=0 immediately; the next full frame after release works normally.

Source files
------------

// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI register responder: frame geometry,
// register addresses, FSM states and the command-byte layout.
package spi_reg_pkg;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned CNT_W      = $clog2(FRAME_BITS);
  localparam int unsigned TRIG_W     = 16;

  localparam logic [6:0] ADDR_ID      = 7'h00;
  localparam logic [6:0] ADDR_SEQ     = 7'h01;
  localparam logic [6:0] ADDR_PG      = 7'h02;
  localparam logic [6:0] ADDR_CTRL    = 7'h03;
  localparam logic [6:0] ADDR_SCRATCH = 7'h04;
  localparam logic [6:0] ADDR_TRIG    = 7'h05;
  localparam logic [6:0] ADDR_ERR     = 7'h06;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA,
    DONE
  } state_e;

  typedef struct packed {
    logic       rw;
    logic [6:0] addr;
  } cmd_t;

endpackage

// File: rtl/spi_reg_responder_sync.sv
// Three-stage synchroniser for an asynchronous pin with rise/fall detection
// taken between the second and third stages.
module spi_pin_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic rise_c,
  output logic fall_c
);

  logic [2:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {3{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[1:0], pin};
    end
  end

  assign rise_c = sync_q[1] & ~sync_q[2];
  assign fall_c = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_reg_responder.sv
// SPI mode-0 register responder, oversampled in the sysclk domain. Exposes ID,
// sequencer state, power-good, control, scratch, camera trigger and error flag.
module spi_reg_responder
  import spi_reg_pkg::*;
#(
  parameter logic [7:0]  DEVICE_ID    = 8'hA5,
  parameter int unsigned PULSE_CYCLES = 16,
  parameter logic [7:0]  CTRL_RESET   = 8'h00
) (
  input  logic       sysclk,
  input  logic       reset_INV,
  input  logic       spi_clk,
  input  logic       spi_mosi,
  input  logic       spi_cs_INV,
  output logic       spi_miso,
  input  logic [3:0] seq_state,
  input  logic [7:0] pg_flags,
  output logic [7:0] ctrl,
  output logic       camera_trigger,
  output logic       frame_err
);

  logic clk_rise, clk_fall, cs_rise, cs_fall;
  logic [1:0] mosi_q;
  logic       mosi_s;

  spi_pin_sync #(.RESET_VAL(1'b0)) u_clk_sync (
    .clk    (sysclk),
    .rst_n  (reset_INV),
    .pin    (spi_clk),
    .rise_c (clk_rise),
    .fall_c (clk_fall)
  );

  spi_pin_sync #(.RESET_VAL(1'b1)) u_cs_sync (
    .clk    (sysclk),
    .rst_n  (reset_INV),
    .pin    (spi_cs_INV),
    .rise_c (cs_rise),
    .fall_c (cs_fall)
  );

  // MOSI needs only two stages: it lines up with the synchronised SCLK level.
  always_ff @(posedge sysclk or negedge reset_INV) begin
    if (!reset_INV) begin
      mosi_q <= 2'b00;
    end else begin
      mosi_q <= {mosi_q[0], spi_mosi};
    end
  end
  assign mosi_s = mosi_q[1];

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    bitcnt_q, bitcnt_d;
  logic [6:0]          rx_q, rx_d;
  logic [7:0]          tx_q, tx_d;
  cmd_t                cmd_q, cmd_d;
  logic                miso_q, miso_d;
  logic [7:0]          ctrl_q, ctrl_d;
  logic [7:0]          scratch_q, scratch_d;
  logic                err_q, err_d;
  logic [TRIG_W-1:0]   trig_cnt_q, trig_cnt_d;
  logic                trig_q, trig_d;
  logic                frame_done;
  logic [6:0]          rd_addr;
  logic [7:0]          rd_data;
  logic [7:0]          wr_data;

  // Read mux, evaluated with the address completing on the 8th rising edge.
  always_comb begin
    rd_addr = {rx_q[5:0], mosi_s};
    wr_data = {rx_q[6:0], mosi_s};
    rd_data = 8'h00;
    case (rd_addr)
      ADDR_ID:      rd_data = DEVICE_ID;
      ADDR_SEQ:     rd_data = {4'b0000, seq_state};
      ADDR_PG:      rd_data = pg_flags;
      ADDR_CTRL:    rd_data = ctrl_q;
      ADDR_SCRATCH: rd_data = scratch_q;
      ADDR_ERR:     rd_data = {7'b0000000, err_q};
      default:      rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge sysclk or negedge reset_INV) begin
    if (!reset_INV) begin
      state_q    <= IDLE;
      bitcnt_q   <= '0;
      rx_q       <= '0;
      tx_q       <= '0;
      cmd_q      <= '0;
      miso_q     <= 1'b0;
      ctrl_q     <= CTRL_RESET;
      scratch_q  <= '0;
      err_q      <= 1'b0;
      trig_cnt_q <= '0;
      trig_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      cmd_q      <= cmd_d;
      miso_q     <= miso_d;
      ctrl_q     <= ctrl_d;
      scratch_q  <= scratch_d;
      err_q      <= err_d;
      trig_cnt_q <= trig_cnt_d;
      trig_q     <= trig_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    cmd_d      = cmd_q;
    miso_d     = miso_q;
    ctrl_d     = ctrl_q;
    scratch_d  = scratch_q;
    err_d      = err_q;
    trig_cnt_d = (trig_cnt_q != '0) ? trig_cnt_q - TRIG_W'(1) : '0;
    frame_done = 1'b0;

    case (state_q)
      IDLE: begin
        // Status byte {seq_state, 0000}: bit7 goes out now, the rest on falls.
        if (cs_fall) begin
          state_d  = CMD;
          bitcnt_d = '0;
          miso_d   = seq_state[3];
          tx_d     = {seq_state[2:0], 5'b00000};
        end
      end
      CMD, DATA: begin
        if (clk_rise) begin
          rx_d     = {rx_q[5:0], mosi_s};
          bitcnt_d = bitcnt_q + CNT_W'(1);
          if ((state_q == CMD) && (bitcnt_q == CNT_W'(7))) begin
            cmd_d   = cmd_t'(wr_data);
            tx_d    = rd_data;
            state_d = DATA;
          end else if ((state_q == DATA) && (bitcnt_q == CNT_W'(FRAME_BITS - 1))) begin
            frame_done = 1'b1;
            state_d    = DONE;
            miso_d     = 1'b0;
            if (!cmd_q.rw) begin
              case (cmd_q.addr)
                ADDR_CTRL:    ctrl_d    = wr_data;
                ADDR_SCRATCH: scratch_d = wr_data;
                ADDR_TRIG:    if (wr_data[0]) trig_cnt_d = TRIG_W'(PULSE_CYCLES);
                default:      ;
              endcase
            end else if (cmd_q.addr == ADDR_ERR) begin
              err_d = 1'b0;
            end
          end
        end else if (clk_fall) begin
          miso_d = tx_q[7];
          tx_d   = {tx_q[6:0], 1'b0};
        end
      end
      DONE: begin
        miso_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A completing 16th edge in this same cycle wins over the abort.
    if (cs_rise) begin
      if ((state_q == CMD) || ((state_q == DATA) && !frame_done)) begin
        err_d = 1'b1;
      end
      state_d  = IDLE;
      bitcnt_d = '0;
      miso_d   = 1'b0;
    end

    trig_d = (trig_cnt_d != '0);
  end

  assign spi_miso       = miso_q;
  assign ctrl           = ctrl_q;
  assign camera_trigger = trig_q;
  assign frame_err      = err_q;

endmodule

// File: tb/tb_spi_reg_responder.sv
// Directed self-checking bench for spi_reg_responder: SCLK = sysclk/10,
// all host-side pins driven on the sysclk falling edge.
module tb_spi_reg_responder;

  localparam int unsigned PULSE = 200;

  logic       sysclk = 1'b0;
  logic       reset_INV;
  logic       spi_clk;
  logic       spi_mosi;
  logic       spi_cs_INV;
  logic       spi_miso;
  logic [3:0] seq_state;
  logic [7:0] pg_flags;
  logic [7:0] ctrl;
  logic       camera_trigger;
  logic       frame_err;

  int   n_err = 0;
  int   n_chk = 0;
  int   cyc = 0;
  int   high_total = 0;
  int   rise_total = 0;
  logic trig_prev = 1'b0;

  spi_reg_responder #(
    .DEVICE_ID    (8'hA5),
    .PULSE_CYCLES (PULSE),
    .CTRL_RESET   (8'h00)
  ) dut (
    .sysclk         (sysclk),
    .reset_INV      (reset_INV),
    .spi_clk        (spi_clk),
    .spi_mosi       (spi_mosi),
    .spi_cs_INV     (spi_cs_INV),
    .spi_miso       (spi_miso),
    .seq_state      (seq_state),
    .pg_flags       (pg_flags),
    .ctrl           (ctrl),
    .camera_trigger (camera_trigger),
    .frame_err      (frame_err)
  );

  always #5 sysclk = ~sysclk;

  always @(posedge sysclk) cyc <= cyc + 1;

  // Running totals of trigger-high cycles and trigger rising edges.
  always @(negedge sysclk) begin
    high_total <= high_total + (camera_trigger ? 1 : 0);
    if (camera_trigger && !trig_prev) rise_total <= rise_total + 1;
    trig_prev <= camera_trigger;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  // CS low and nbits SCLK cycles; CS is left low. rx captures MISO at each rise.
  task automatic spi_bits(input logic [15:0] word, input int nbits, input int chg_bit,
                          input logic [7:0] chg_val, output logic [15:0] rx, output int last_rise);
    rx = '0;
    last_rise = 0;
    spi_cs_INV = 1'b0;
    spi_mosi = word[15];
    tick(5);
    for (int i = 0; i < nbits; i++) begin
      if (i == chg_bit) pg_flags = chg_val;
      rx[15-i] = spi_miso;
      spi_clk = 1'b1;
      last_rise = cyc;
      tick(5);
      spi_clk = 1'b0;
      if (i < 15) spi_mosi = word[14-i];
      tick(5);
    end
  endtask

  task automatic spi_release();
    spi_cs_INV = 1'b1;
    spi_mosi = 1'b0;
    tick(10);
  endtask

  task automatic spi_xfer(input logic [7:0] b0, input logic [7:0] b1,
                          output logic [7:0] r0, output logic [7:0] r1, output int last_rise);
    logic [15:0] w;
    spi_bits({b0, b1}, 16, -1, 8'h00, w, last_rise);
    spi_release();
    r0 = w[15:8];
    r1 = w[7:0];
  endtask

  initial begin
    logic [7:0]  r0, r1;
    logic [15:0] w;
    int lr, lr1, lr2, h0, q0;

    reset_INV = 1'b0;
    spi_clk = 1'b0;
    spi_mosi = 1'b0;
    spi_cs_INV = 1'b1;
    seq_state = 4'h9;
    pg_flags = 8'h00;
    tick(3);
    check("rst_miso", 16'(spi_miso), 16'h0);
    check("rst_ctrl", 16'(ctrl), 16'h00);
    check("rst_trig", 16'(camera_trigger), 16'h0);
    check("rst_ferr", 16'(frame_err), 16'h0);
    reset_INV = 1'b1;
    tick(5);

    spi_xfer(8'h80, 8'h00, r0, r1, lr);
    check("id_status", 16'(r0), 16'h90);
    check("id_data", 16'(r1), 16'hA5);
    check("id_ferr", 16'(frame_err), 16'h0);

    spi_xfer(8'h81, 8'h00, r0, r1, lr);
    check("seq_data", 16'(r1), 16'h09);
    spi_xfer(8'hFF, 8'h00, r0, r1, lr);
    check("unmapped_rd", 16'(r1), 16'h00);

    // Write ctrl, checking the 3-sysclk latency from the 16th rising edge.
    spi_bits(16'h035A, 15, -1, 8'h00, w, lr);
    spi_clk = 1'b1;
    tick(2);
    check("ctrl_early", 16'(ctrl), 16'h00);
    tick(1);
    check("ctrl_commit", 16'(ctrl), 16'h5A);
    tick(2);
    spi_clk = 1'b0;
    tick(5);
    spi_release();

    spi_xfer(8'h83, 8'h00, r0, r1, lr);
    check("ctrl_rd", 16'(r1), 16'h5A);
    check("ctrl_rd_status", 16'(r0), 16'h90);

    spi_xfer(8'h7F, 8'hFF, r0, r1, lr);
    check("unmapped_wr_ctrl", 16'(ctrl), 16'h5A);
    spi_xfer(8'h84, 8'h00, r0, r1, lr);
    check("scratch_init", 16'(r1), 16'h00);
    check("unmapped_wr_trig", 16'(camera_trigger), 16'h0);

    pg_flags = 8'h3C;
    spi_bits(16'h8200, 16, 11, 8'hFF, w, lr);
    spi_release();
    check("pg_snapshot", 16'(w[7:0]), 16'h3C);
    spi_xfer(8'h82, 8'h00, r0, r1, lr);
    check("pg_fresh", 16'(r1), 16'hFF);

    spi_xfer(8'h04, 8'h77, r0, r1, lr);
    spi_xfer(8'h84, 8'h00, r0, r1, lr);
    check("scratch_rd", 16'(r1), 16'h77);

    // Abort after 12 bits: no commit, sticky error, clear-on-read.
    spi_bits(16'h0411, 12, -1, 8'h00, w, lr);
    spi_release();
    check("abort_ferr", 16'(frame_err), 16'h1);
    spi_xfer(8'h84, 8'h00, r0, r1, lr);
    check("abort_scratch", 16'(r1), 16'h77);
    spi_xfer(8'h86, 8'h00, r0, r1, lr);
    check("err_rd1", 16'(r1), 16'h01);
    check("err_cleared", 16'(frame_err), 16'h0);
    spi_xfer(8'h86, 8'h00, r0, r1, lr);
    check("err_rd2", 16'(r1), 16'h00);

    h0 = high_total;
    q0 = rise_total;
    spi_xfer(8'h05, 8'h00, r0, r1, lr);
    tick(20);
    check("trig_bit0_zero", 16'(rise_total - q0), 16'd0);

    h0 = high_total;
    q0 = rise_total;
    spi_xfer(8'h05, 8'h01, r0, r1, lr);
    tick(250);
    check("trig_width", 16'(high_total - h0), 16'(PULSE));
    check("trig_single_rise", 16'(rise_total - q0), 16'd1);

    // Retrigger while still high: pulse extends by the commit spacing.
    h0 = high_total;
    q0 = rise_total;
    spi_xfer(8'h05, 8'h01, r0, r1, lr1);
    spi_xfer(8'h05, 8'h01, r0, r1, lr2);
    tick(250);
    check("retrig_width", 16'(high_total - h0), 16'(PULSE + (lr2 - lr1)));
    check("retrig_no_gap", 16'(rise_total - q0), 16'd1);

    // Asynchronous reset in the DATA phase of a ctrl write.
    spi_bits(16'h03FF, 11, -1, 8'h00, w, lr);
    check("pre_rst_miso", 16'(spi_miso), 16'h1);
    reset_INV = 1'b0;
    #1;
    check("midrst_ctrl", 16'(ctrl), 16'h00);
    check("midrst_miso", 16'(spi_miso), 16'h0);
    spi_cs_INV = 1'b1;
    spi_mosi = 1'b0;
    tick(3);
    reset_INV = 1'b1;
    tick(5);
    spi_xfer(8'h03, 8'h3C, r0, r1, lr);
    check("post_rst_ctrl", 16'(ctrl), 16'h3C);
    spi_xfer(8'h83, 8'h00, r0, r1, lr);
    check("post_rst_rd", 16'(r1), 16'h3C);
    check("post_rst_ferr", 16'(frame_err), 16'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
